// File: rtl/split_sched_pkg.sv
// Shared types and helpers for the split-constraint evaluation scheduler.
package split_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } split_sched_state_e;

  // Index width for n checkers; never below one bit so ports stay legal.
  function automatic int split_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/split_eval_sched.sv
// Steps split_sel across NUM_SPLITS checkers, ANDs their results and returns a verdict.
// Optional early exit on the first failing checker: define SPLIT_SCHED_EARLY_EXIT_EN.
module split_eval_sched
  import split_sched_pkg::*;
#(
  parameter  int NUM_SPLITS = 64,
  localparam int CNT_W      = split_cnt_w(NUM_SPLITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  output logic             split_req,
  output logic [CNT_W-1:0] split_sel,
  input  logic             split_ack,
  input  logic             split_x,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             sat,
  output logic [CNT_W-1:0] fail_idx,
  output logic [CNT_W:0]   fail_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SPLITS - 1);
  localparam logic [CNT_W:0]   CNT_MAX  = (CNT_W + 1)'(NUM_SPLITS);

  split_sched_state_e state_q, state_d;

  logic [CNT_W-1:0] idx_q;
  logic             sat_q;
  logic [CNT_W-1:0] fail_idx_q;
  logic [CNT_W:0]   fail_cnt_q;

  logic start_fire;
  logic ack_step;
  logic fail_now;
  logic early_fail;
  logic last;

  assign start_ready = (state_q == IDLE) & rst_n & ~abort;
  assign start_fire  = start_valid & start_ready;
  assign fail_now    = split_ack & ~split_x;
  assign last        = (idx_q == LAST_IDX);
  assign ack_step    = (state_q == EVAL) & split_ack & ~abort;

`ifdef SPLIT_SCHED_EARLY_EXIT_EN
  assign early_fail = fail_now;
`else
  assign early_fail = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_fire) state_d = EVAL;
      EVAL: if (split_ack && (last || early_fail)) state_d = DONE;
      DONE: if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // sat_q doubles as "no failure seen yet", marking the first failing index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      sat_q      <= 1'b0;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
    end else if (start_fire) begin
      idx_q      <= '0;
      sat_q      <= 1'b1;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
    end else if (ack_step) begin
      if (fail_now) begin
        sat_q <= 1'b0;
        if (sat_q) fail_idx_q <= idx_q;
        if (fail_cnt_q != CNT_MAX) fail_cnt_q <= fail_cnt_q + 1'b1;
      end
      if (!last && !early_fail) idx_q <= idx_q + 1'b1;
    end
  end

  assign split_req  = (state_q == EVAL);
  assign split_sel  = idx_q;
  assign done_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign sat        = sat_q;
  assign fail_idx   = fail_idx_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_split_eval_sched.sv
// Directed bench for split_eval_sched with NUM_SPLITS=4; expectations follow
// SPLIT_SCHED_EARLY_EXIT_EN when the bench is built with it defined.
module tb_split_eval_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       abort = 1'b0;
  logic       split_req;
  logic [1:0] split_sel;
  logic       split_ack;
  logic       split_x;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic       sat;
  logic [1:0] fail_idx;
  logic [2:0] fail_cnt;
  logic       busy;

  logic [3:0] pass_mask = 4'b1111;
  int         ack_delay = 0;
  int         wait_cnt  = 0;
  int         checks    = 0;
  int         errors    = 0;

  always #5 clk = ~clk;

  split_eval_sched #(.NUM_SPLITS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .abort(abort),
    .split_req(split_req), .split_sel(split_sel),
    .split_ack(split_ack), .split_x(split_x),
    .done_valid(done_valid), .done_ready(done_ready),
    .sat(sat), .fail_idx(fail_idx), .fail_cnt(fail_cnt), .busy(busy)
  );

  // Checker bank model: result from pass_mask, ack after ack_delay wait cycles.
  always @(posedge clk) begin
    if (!split_req || split_ack) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    split_x   = pass_mask[split_sel];
    split_ack = split_req && (wait_cnt >= ack_delay);
  end

  task automatic do_start(input string name);
    start_valid = 1'b1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start_ready got %b want 1", name, start_ready);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge (cycle 1); counts cycles to done_valid.
  task automatic wait_done(input string name, input int exp_cyc, input logic exp_sat,
                           input logic [1:0] exp_idx, input logic [2:0] exp_cnt);
    int cyc = 1;
    logic [1:0] exp_sel;
    while (!done_valid && cyc < 60) begin
      if (split_req) begin
        exp_sel = 2'((cyc - 1) / (ack_delay + 1));
        checks++;
        if (split_sel !== exp_sel) begin
          errors++;
          $display("FAIL %s split_sel cycle %0d got %0d want %0d", name, cyc, split_sel, exp_sel);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!done_valid) begin
      errors++;
      $display("FAIL %s timeout waiting for done_valid", name);
    end else if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s done cycle got %0d want %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (sat !== exp_sat || fail_idx !== exp_idx || fail_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s verdict got sat=%b idx=%0d cnt=%0d want sat=%b idx=%0d cnt=%0d",
               name, sat, fail_idx, fail_cnt, exp_sat, exp_idx, exp_cnt);
    end
  endtask

  task automatic finish_done(input string name);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after accept got start_ready=%b done_valid=%b busy=%b want 1 0 0",
               name, start_ready, done_valid, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (start_ready !== 1'b0 || busy !== 1'b0 || done_valid !== 1'b0 || split_req !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl got start_ready=%b busy=%b done_valid=%b split_req=%b want 0 0 0 0",
               start_ready, busy, done_valid, split_req);
    end
    checks++;
    if (sat !== 1'b0 || fail_idx !== 2'd0 || fail_cnt !== 3'd0 || split_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset regs got sat=%b idx=%0d cnt=%0d sel=%0d want 0 0 0 0",
               sat, fail_idx, fail_cnt, split_sel);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release start_ready got %b want 1", start_ready);
    end
  endtask

  task automatic test_full_pass();
    pass_mask = 4'b1111;
    ack_delay = 0;
    do_start("full_pass");
    wait_done("full_pass", 5, 1'b1, 2'd0, 3'd0);
    finish_done("full_pass");
  endtask

  task automatic test_fail_pattern();
    pass_mask = 4'b0101;
    ack_delay = 0;
    do_start("fail_pattern");
`ifdef SPLIT_SCHED_EARLY_EXIT_EN
    wait_done("fail_pattern", 3, 1'b0, 2'd1, 3'd1);
`else
    wait_done("fail_pattern", 5, 1'b0, 2'd1, 3'd2);
`endif
    finish_done("fail_pattern");
  endtask

  task automatic test_ack_delay();
    pass_mask = 4'b1111;
    ack_delay = 2;
    do_start("ack_delay");
    wait_done("ack_delay", 13, 1'b1, 2'd0, 3'd0);
    finish_done("ack_delay");
    ack_delay = 0;
  endtask

  task automatic test_done_hold();
    pass_mask = 4'b1011;
    do_start("done_hold");
`ifdef SPLIT_SCHED_EARLY_EXIT_EN
    wait_done("done_hold", 4, 1'b0, 2'd2, 3'd1);
`else
    wait_done("done_hold", 5, 1'b0, 2'd2, 3'd1);
`endif
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (done_valid !== 1'b1 || start_ready !== 1'b0 || sat !== 1'b0 ||
          fail_idx !== 2'd2 || fail_cnt !== 3'd1) begin
        errors++;
        $display("FAIL done_hold cycle %0d got dv=%b sr=%b sat=%b idx=%0d cnt=%0d want 1 0 0 2 1",
                 i, done_valid, start_ready, sat, fail_idx, fail_cnt);
      end
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    finish_done("done_hold");
  endtask

  task automatic test_abort();
    pass_mask = 4'b1111;
    do_start("abort");
    @(posedge clk); #1;
    abort = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done_valid !== 1'b0 || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort exit got busy=%b done_valid=%b start_ready=%b want 0 0 0",
               busy, done_valid, start_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins_start busy got %b want 0", busy);
    end
    abort = 1'b0;
    start_valid = 1'b0;
    begin
      logic seen_done = 1'b0;
      repeat (4) begin
        if (done_valid !== 1'b0) seen_done = 1'b1;
        @(posedge clk); #1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_verdict done_valid seen got 1 want 0");
      end
    end
    do_start("abort_rerun");
    wait_done("abort_rerun", 5, 1'b1, 2'd0, 3'd0);
    finish_done("abort_rerun");
  endtask

  task automatic test_reset_mid_run();
    pass_mask = 4'b1110;
    do_start("reset_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (fail_cnt !== 3'd1 || sat !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre got cnt=%0d sat=%b busy=%b want 1 0 1", fail_cnt, sat, busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (fail_cnt !== 3'd0 || sat !== 1'b0 || busy !== 1'b0 || fail_idx !== 2'd0 ||
        start_ready !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got cnt=%0d sat=%b busy=%b idx=%0d sr=%b dv=%b want 0 0 0 0 0 0",
               fail_cnt, sat, busy, fail_idx, start_ready, done_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid release got sr=%b busy=%b want 1 0", start_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_fail_pattern();
    test_ack_delay();
    test_done_hold();
    test_abort();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
